// File: rtl/issue_scoreboard_pkg.sv
// Shared types, constants and hazard helpers for the issue scoreboard.
package issue_scoreboard_pkg;

  localparam int unsigned NREG  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned RDT_W = 2;

  localparam logic [RDT_W-1:0] RD_NONE = 2'd0;
  localparam logic [RDT_W-1:0] RD_INT  = 2'd1;
  localparam logic [RDT_W-1:0] RD_FP   = 2'd2;

  typedef enum logic [1:0] {IDLE, HALF, DRAIN, DONE} sb_state_t;

  // One decoded instruction slot as seen by the scoreboard.
  typedef struct packed {
    logic             valid;
    logic             rs1_valid;
    logic             rs2_valid;
    logic             rs3_valid;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rs3;
    logic             rs1_fp;
    logic             rs2_fp;
    logic [RDT_W-1:0] rd_type;
    logic [REG_W-1:0] rd;
    logic             endsim;
  } inst_t;

  // RAW or WAW against the registered busy state.
  function automatic logic slot_hazard(inst_t ins, logic [NREG-1:0] ib, logic [NREG-1:0] fb);
    logic raw;
    logic waw;
    raw = (ins.rs1_valid & (ins.rs1_fp ? fb[ins.rs1] : ib[ins.rs1])) |
          (ins.rs2_valid & (ins.rs2_fp ? fb[ins.rs2] : ib[ins.rs2])) |
          (ins.rs3_valid & fb[ins.rs3]);
    waw = (ins.rd_type == RD_INT) ? ib[ins.rd] :
          (ins.rd_type == RD_FP)  ? fb[ins.rd] : 1'b0;
    return raw | waw;
  endfunction

  // inst1 touches the register inst0 is about to write (int x0 excluded).
  function automatic logic pair_hazard(inst_t i0, inst_t i1);
    logic wr;
    logic dfp;
    wr  = ((i0.rd_type == RD_INT) && (i0.rd != '0)) || (i0.rd_type == RD_FP);
    dfp = (i0.rd_type == RD_FP);
    return wr & (
      (i1.rs1_valid && (i1.rs1_fp == dfp) && (i1.rs1 == i0.rd)) ||
      (i1.rs2_valid && (i1.rs2_fp == dfp) && (i1.rs2 == i0.rd)) ||
      (i1.rs3_valid && dfp && (i1.rs3 == i0.rd)) ||
      ((i1.rd_type == RD_INT) && !dfp && (i1.rd == i0.rd)) ||
      ((i1.rd_type == RD_FP) && dfp && (i1.rd == i0.rd)));
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decoder, writeback and status signals of the issue scoreboard.
interface issue_scoreboard_if;
  import issue_scoreboard_pkg::*;

  logic             flush_i;
  logic             inst0_valid_i, inst1_valid_i;
  logic             inst0_rs1_valid_i, inst0_rs2_valid_i, inst0_rs3_valid_i;
  logic             inst1_rs1_valid_i, inst1_rs2_valid_i, inst1_rs3_valid_i;
  logic [REG_W-1:0] inst0_rs1_i, inst0_rs2_i, inst0_rs3_i;
  logic [REG_W-1:0] inst1_rs1_i, inst1_rs2_i, inst1_rs3_i;
  logic             inst0_rs1_fp_i, inst0_rs2_fp_i, inst1_rs1_fp_i, inst1_rs2_fp_i;
  logic [RDT_W-1:0] inst0_rd_type_i, inst1_rd_type_i;
  logic [REG_W-1:0] inst0_rd_i, inst1_rd_i;
  logic             inst0_endsim_i, inst1_endsim_i;
  logic             wb0_valid_i, wb1_valid_i;
  logic [REG_W-1:0] wb0_rd_i, wb1_rd_i;
  logic             wb0_fp_i, wb1_fp_i;
  logic             stall_o, issue0_o, issue1_o, endsim_o;
  logic [NREG-1:0]  int_busy_o, fp_busy_o;

  modport master (
    output flush_i, inst0_valid_i, inst1_valid_i,
           inst0_rs1_valid_i, inst0_rs2_valid_i, inst0_rs3_valid_i,
           inst1_rs1_valid_i, inst1_rs2_valid_i, inst1_rs3_valid_i,
           inst0_rs1_i, inst0_rs2_i, inst0_rs3_i, inst1_rs1_i, inst1_rs2_i, inst1_rs3_i,
           inst0_rs1_fp_i, inst0_rs2_fp_i, inst1_rs1_fp_i, inst1_rs2_fp_i,
           inst0_rd_type_i, inst1_rd_type_i, inst0_rd_i, inst1_rd_i,
           inst0_endsim_i, inst1_endsim_i,
           wb0_valid_i, wb1_valid_i, wb0_rd_i, wb1_rd_i, wb0_fp_i, wb1_fp_i,
    input  stall_o, issue0_o, issue1_o, endsim_o, int_busy_o, fp_busy_o
  );

  modport slave (
    input  flush_i, inst0_valid_i, inst1_valid_i,
           inst0_rs1_valid_i, inst0_rs2_valid_i, inst0_rs3_valid_i,
           inst1_rs1_valid_i, inst1_rs2_valid_i, inst1_rs3_valid_i,
           inst0_rs1_i, inst0_rs2_i, inst0_rs3_i, inst1_rs1_i, inst1_rs2_i, inst1_rs3_i,
           inst0_rs1_fp_i, inst0_rs2_fp_i, inst1_rs1_fp_i, inst1_rs2_fp_i,
           inst0_rd_type_i, inst1_rd_type_i, inst0_rd_i, inst1_rd_i,
           inst0_endsim_i, inst1_endsim_i,
           wb0_valid_i, wb1_valid_i, wb0_rd_i, wb1_rd_i, wb0_fp_i, wb1_fp_i,
    output stall_o, issue0_o, issue1_o, endsim_o, int_busy_o, fp_busy_o
  );
endinterface

// File: rtl/issue_scoreboard_busy_table.sv
// Integer/FP busy bits with two set ports, two clear ports and clear-all.
module sb_busy_table
  import issue_scoreboard_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr_all,
  input  logic [1:0]            i_set_en,
  input  logic [1:0]            i_set_fp,
  input  logic [1:0][REG_W-1:0] i_set_rd,
  input  logic [1:0]            i_clr_en,
  input  logic [1:0]            i_clr_fp,
  input  logic [1:0][REG_W-1:0] i_clr_rd,
  output logic [NREG-1:0]       o_int_busy,
  output logic [NREG-1:0]       o_fp_busy,
  output logic                  o_next_zero_c
);

  logic [NREG-1:0] r_int, r_fp;
  logic [NREG-1:0] w_int_set, w_fp_set, w_int_clr, w_fp_clr;
  logic [NREG-1:0] w_int_next, w_fp_next;

  // Decode port indices into masks; sets are applied after clears.
  always_comb begin
    w_int_set = '0;
    w_fp_set  = '0;
    w_int_clr = '0;
    w_fp_clr  = '0;
    for (int p = 0; p < 2; p++) begin
      if (i_set_en[p]) begin
        if (i_set_fp[p]) w_fp_set[i_set_rd[p]]  = 1'b1;
        else             w_int_set[i_set_rd[p]] = 1'b1;
      end
      if (i_clr_en[p]) begin
        if (i_clr_fp[p]) w_fp_clr[i_clr_rd[p]]  = 1'b1;
        else             w_int_clr[i_clr_rd[p]] = 1'b1;
      end
    end
    w_int_set[0] = 1'b0;
    w_int_next   = (r_int & ~w_int_clr) | w_int_set;
    w_fp_next    = (r_fp & ~w_fp_clr) | w_fp_set;
  end

  // Busy state register; clear-all overrides every port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int <= '0;
      r_fp  <= '0;
    end else if (i_clr_all) begin
      r_int <= '0;
      r_fp  <= '0;
    end else begin
      r_int <= w_int_next;
      r_fp  <= w_fp_next;
    end
  end

  assign o_int_busy    = r_int;
  assign o_fp_busy     = r_fp;
  assign o_next_zero_c = ~(|w_int_next) & ~(|w_fp_next);

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-issue hazard scoreboard: hazard checks, pair splitting and drain FSM.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  issue_scoreboard_if.slave  sb
);

  sb_state_t       r_state, w_state_next;
  logic            r_endsim, w_endsim_next;
  logic            w_stall, w_issue0, w_issue1, w_clr_all;
  logic            w_haz0, w_haz1, w_pair, w_next_zero;
  logic [NREG-1:0] w_int_busy, w_fp_busy;
  inst_t           w_inst0, w_inst1;

  assign w_inst0 = '{valid: sb.inst0_valid_i, rs1_valid: sb.inst0_rs1_valid_i,
                     rs2_valid: sb.inst0_rs2_valid_i, rs3_valid: sb.inst0_rs3_valid_i,
                     rs1: sb.inst0_rs1_i, rs2: sb.inst0_rs2_i, rs3: sb.inst0_rs3_i,
                     rs1_fp: sb.inst0_rs1_fp_i, rs2_fp: sb.inst0_rs2_fp_i,
                     rd_type: sb.inst0_rd_type_i, rd: sb.inst0_rd_i, endsim: sb.inst0_endsim_i};
  assign w_inst1 = '{valid: sb.inst1_valid_i, rs1_valid: sb.inst1_rs1_valid_i,
                     rs2_valid: sb.inst1_rs2_valid_i, rs3_valid: sb.inst1_rs3_valid_i,
                     rs1: sb.inst1_rs1_i, rs2: sb.inst1_rs2_i, rs3: sb.inst1_rs3_i,
                     rs1_fp: sb.inst1_rs1_fp_i, rs2_fp: sb.inst1_rs2_fp_i,
                     rd_type: sb.inst1_rd_type_i, rd: sb.inst1_rd_i, endsim: sb.inst1_endsim_i};

  assign w_haz0 = w_inst0.valid & slot_hazard(w_inst0, w_int_busy, w_fp_busy);
  assign w_haz1 = w_inst1.valid & slot_hazard(w_inst1, w_int_busy, w_fp_busy);
  assign w_pair = w_inst0.valid & w_inst1.valid & pair_hazard(w_inst0, w_inst1);

  sb_busy_table u_busy (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr_all    (w_clr_all),
    .i_set_en     ({w_issue1 & ((w_inst1.rd_type == RD_INT) | (w_inst1.rd_type == RD_FP)),
                    w_issue0 & ((w_inst0.rd_type == RD_INT) | (w_inst0.rd_type == RD_FP))}),
    .i_set_fp     ({w_inst1.rd_type == RD_FP, w_inst0.rd_type == RD_FP}),
    .i_set_rd     ({w_inst1.rd, w_inst0.rd}),
    .i_clr_en     ({sb.wb1_valid_i, sb.wb0_valid_i}),
    .i_clr_fp     ({sb.wb1_fp_i, sb.wb0_fp_i}),
    .i_clr_rd     ({sb.wb1_rd_i, sb.wb0_rd_i}),
    .o_int_busy   (w_int_busy),
    .o_fp_busy    (w_fp_busy),
    .o_next_zero_c(w_next_zero)
  );

  // Next state, issue enables and stall from registered state and decoder pair.
  always_comb begin
    w_state_next  = r_state;
    w_endsim_next = 1'b0;
    w_stall       = 1'b0;
    w_issue0      = 1'b0;
    w_issue1      = 1'b0;
    w_clr_all     = 1'b0;
    case (r_state)
      IDLE: begin
        if (sb.flush_i) begin
          w_clr_all = 1'b1;
        end else if (w_haz0) begin
          w_stall = 1'b1;
        end else begin
          w_issue0 = w_inst0.valid;
          if (w_inst0.valid && w_inst0.endsim) begin
            w_state_next = DRAIN;
          end else if (w_haz1 || w_pair) begin
            w_stall      = 1'b1;
            w_state_next = HALF;
          end else begin
            w_issue1 = w_inst1.valid;
            if (w_inst1.valid && w_inst1.endsim) w_state_next = DRAIN;
          end
        end
      end
      HALF: begin
        if (sb.flush_i) begin
          w_clr_all    = 1'b1;
          w_state_next = IDLE;
        end else if (w_haz1) begin
          w_stall = 1'b1;
        end else begin
          w_issue1     = w_inst1.valid;
          w_state_next = (w_inst1.valid && w_inst1.endsim) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (sb.flush_i) begin
          w_clr_all    = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_stall = 1'b1;
          if (w_next_zero) begin
            w_state_next  = DONE;
            w_endsim_next = 1'b1;
          end
        end
      end
      DONE:    w_stall = 1'b1;
      default: w_state_next = IDLE;
    endcase
  end

  // State and end-of-simulation pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_endsim <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_endsim <= w_endsim_next;
    end
  end

  assign sb.stall_o    = w_stall;
  assign sb.issue0_o   = w_issue0;
  assign sb.issue1_o   = w_issue1;
  assign sb.endsim_o   = r_endsim;
  assign sb.int_busy_o = w_int_busy;
  assign sb.fp_busy_o  = w_fp_busy;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized scoreboard bench for issue_scoreboard against a behavioural model.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  issue_scoreboard_if sb();
  issue_scoreboard dut (.clk(clk), .rst_n(rst_n), .sb(sb));

  inst_t      t0, t1;
  logic       flush;
  logic       wb0_v, wb1_v, wb0_fp, wb1_fp;
  logic [4:0] wb0_rd, wb1_rd;

  assign sb.flush_i = flush;
  assign sb.inst0_valid_i = t0.valid;         assign sb.inst1_valid_i = t1.valid;
  assign sb.inst0_rs1_valid_i = t0.rs1_valid; assign sb.inst1_rs1_valid_i = t1.rs1_valid;
  assign sb.inst0_rs2_valid_i = t0.rs2_valid; assign sb.inst1_rs2_valid_i = t1.rs2_valid;
  assign sb.inst0_rs3_valid_i = t0.rs3_valid; assign sb.inst1_rs3_valid_i = t1.rs3_valid;
  assign sb.inst0_rs1_i = t0.rs1;             assign sb.inst1_rs1_i = t1.rs1;
  assign sb.inst0_rs2_i = t0.rs2;             assign sb.inst1_rs2_i = t1.rs2;
  assign sb.inst0_rs3_i = t0.rs3;             assign sb.inst1_rs3_i = t1.rs3;
  assign sb.inst0_rs1_fp_i = t0.rs1_fp;       assign sb.inst1_rs1_fp_i = t1.rs1_fp;
  assign sb.inst0_rs2_fp_i = t0.rs2_fp;       assign sb.inst1_rs2_fp_i = t1.rs2_fp;
  assign sb.inst0_rd_type_i = t0.rd_type;     assign sb.inst1_rd_type_i = t1.rd_type;
  assign sb.inst0_rd_i = t0.rd;               assign sb.inst1_rd_i = t1.rd;
  assign sb.inst0_endsim_i = t0.endsim;       assign sb.inst1_endsim_i = t1.endsim;
  assign sb.wb0_valid_i = wb0_v;  assign sb.wb0_rd_i = wb0_rd;  assign sb.wb0_fp_i = wb0_fp;
  assign sb.wb1_valid_i = wb1_v;  assign sb.wb1_rd_i = wb1_rd;  assign sb.wb1_fp_i = wb1_fp;

  // Reference model: which registers are outstanding, and what the machine is doing.
  // mode 0: accepting pairs, 1: older slot already taken, 2: draining, 3: finished
  bit m_int [32];
  bit m_fp  [32];
  int m_mode;
  bit m_endsim;

  typedef struct {
    bit          stall, i0, i1, es;
    logic [31:0] ib, fb;
  } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic bit outstanding(bit fp, int idx);
    return fp ? m_fp[idx] : m_int[idx];
  endfunction

  function automatic bit must_wait(inst_t s);
    bit w;
    if (!s.valid) return 1'b0;
    w = (s.rs1_valid && outstanding(s.rs1_fp, int'(s.rs1))) ||
        (s.rs2_valid && outstanding(s.rs2_fp, int'(s.rs2))) ||
        (s.rs3_valid && outstanding(1'b1, int'(s.rs3)));
    if (s.rd_type == 2'd1) w = w || outstanding(1'b0, int'(s.rd));
    if (s.rd_type == 2'd2) w = w || outstanding(1'b1, int'(s.rd));
    return w;
  endfunction

  // Does b touch the register a produces?  Registers identified as file*32+index.
  function automatic bit depends(inst_t a, inst_t b);
    int d;
    int used[$];
    if (!(a.valid && b.valid)) return 1'b0;
    if (a.rd_type == 2'd1 && a.rd != 0) d = int'(a.rd);
    else if (a.rd_type == 2'd2)         d = 32 + int'(a.rd);
    else return 1'b0;
    if (b.rs1_valid) used.push_back((b.rs1_fp ? 32 : 0) + int'(b.rs1));
    if (b.rs2_valid) used.push_back((b.rs2_fp ? 32 : 0) + int'(b.rs2));
    if (b.rs3_valid) used.push_back(32 + int'(b.rs3));
    if (b.rd_type == 2'd1) used.push_back(int'(b.rd));
    if (b.rd_type == 2'd2) used.push_back(32 + int'(b.rd));
    foreach (used[k]) if (used[k] == d) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void produce(inst_t s);
    if (s.rd_type == 2'd1 && s.rd != 0) m_int[s.rd] = 1'b1;
    if (s.rd_type == 2'd2)              m_fp[s.rd]  = 1'b1;
  endfunction

  function automatic bit nothing_outstanding();
    foreach (m_int[k]) if (m_int[k] || m_fp[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void forget_all();
    foreach (m_int[k]) begin m_int[k] = 1'b0; m_fp[k] = 1'b0; end
  endfunction

  // Predict this cycle's outputs, queue them, then advance the model one clock.
  task automatic model_step();
    exp_t e;
    bit   i0 = 0, i1 = 0, st = 0;
    int   nm;
    if (!rst_n) begin forget_all(); m_mode = 0; m_endsim = 0; end
    foreach (m_int[k]) begin e.ib[k] = m_int[k]; e.fb[k] = m_fp[k]; end
    e.es = m_endsim;
    nm = m_mode;
    if (flush && m_mode != 3) nm = 0;
    else if (m_mode == 0) begin
      if (must_wait(t0)) st = 1;
      else begin
        i0 = t0.valid;
        if (i0 && t0.endsim) nm = 2;
        else if (must_wait(t1) || depends(t0, t1)) begin st = 1; nm = 1; end
        else begin i1 = t1.valid; if (i1 && t1.endsim) nm = 2; end
      end
    end else if (m_mode == 1) begin
      if (must_wait(t1)) st = 1;
      else begin i1 = t1.valid; nm = (i1 && t1.endsim) ? 2 : 0; end
    end else st = 1;
    e.stall = st; e.i0 = i0; e.i1 = i1;
    q.push_back(e);
    if (rst_n) begin
      m_endsim = 0;
      if (flush && m_mode != 3) forget_all();
      else begin
        if (wb0_v) begin if (wb0_fp) m_fp[wb0_rd] = 0; else m_int[wb0_rd] = 0; end
        if (wb1_v) begin if (wb1_fp) m_fp[wb1_rd] = 0; else m_int[wb1_rd] = 0; end
        if (i0) produce(t0);
        if (i1) produce(t1);
        if (m_mode == 2 && nothing_outstanding()) begin nm = 3; m_endsim = 1; end
      end
      m_mode = nm;
    end
  endtask

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Monitor: compares DUT outputs with the oldest prediction each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("stall",    32'(sb.stall_o),  32'(e.stall));
        check("issue0",   32'(sb.issue0_o), 32'(e.i0));
        check("issue1",   32'(sb.issue1_o), 32'(e.i1));
        check("endsim",   32'(sb.endsim_o), 32'(e.es));
        check("int_busy", sb.int_busy_o,    e.ib);
        check("fp_busy",  sb.fp_busy_o,     e.fb);
      end
    end
  end

  task automatic cyc();
    #1 model_step();
    @(negedge clk);
  endtask

  function automatic inst_t mk(logic [1:0] rdt, logic [4:0] rd, bit s1v, logic [4:0] s1, bit s1f, bit es);
    inst_t s = '0;
    s.valid = 1'b1; s.rd_type = rdt; s.rd = rd;
    s.rs1_valid = s1v; s.rs1 = s1; s.rs1_fp = s1f; s.endsim = es;
    return s;
  endfunction

  function automatic inst_t rnd_slot(bit allow_end);
    inst_t s;
    s.valid     = ($urandom % 4) != 0;
    s.rs1_valid = 1'($urandom); s.rs2_valid = 1'($urandom); s.rs3_valid = ($urandom % 4) == 0;
    s.rs1 = 5'($urandom % 8); s.rs2 = 5'($urandom % 8); s.rs3 = 5'($urandom % 8);
    s.rs1_fp = 1'($urandom); s.rs2_fp = 1'($urandom);
    s.rd_type = 2'($urandom % 3); s.rd = 5'($urandom % 8);
    s.endsim = allow_end && (($urandom % 120) == 0);
    return s;
  endfunction

  task automatic quiet();
    t0 = '0; t1 = '0; flush = 0;
    wb0_v = 0; wb1_v = 0; wb0_fp = 0; wb1_fp = 0; wb0_rd = '0; wb1_rd = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    t0 = rnd_slot(1'b1); t1 = rnd_slot(1'b1);
    t0.valid = 0; t1.valid = 0;
    cyc(); cyc();
    quiet();
    rst_n = 1;
  endtask

  initial begin
    quiet();
    rst_n = 0;
    @(negedge clk);
    do_reset();
    // Producer x5, dependent pair waits for wb0 x5 in cycle 4, issues in cycle 5.
    t0 = mk(RD_INT, 5'd5, 0, 5'd0, 0, 0); cyc();
    t0 = mk(RD_NONE, 5'd0, 1, 5'd5, 0, 0); t1 = mk(RD_NONE, 5'd0, 1, 5'd5, 0, 0);
    cyc(); cyc(); cyc();
    wb0_v = 1; wb0_rd = 5'd5; cyc();
    wb0_v = 0; cyc();
    quiet(); cyc();
    // Dependent pair x3: split, then inst1 after wb x3.
    t0 = mk(RD_INT, 5'd3, 0, 5'd0, 0, 0); t1 = mk(RD_NONE, 5'd0, 1, 5'd3, 0, 0);
    cyc(); cyc();
    wb1_v = 1; wb1_rd = 5'd3; cyc();
    wb1_v = 0; cyc();
    quiet(); cyc();
    // Set beats same-cycle clear on x7; a write to x0 never marks busy.
    t0 = mk(RD_INT, 5'd7, 0, 5'd0, 0, 0); wb1_v = 1; wb1_rd = 5'd7; cyc();
    quiet(); t0 = mk(RD_INT, 5'd0, 0, 5'd0, 0, 0); cyc();
    quiet(); wb0_v = 1; wb0_rd = 5'd7; wb1_v = 1; wb1_rd = 5'd7; cyc();
    quiet(); cyc();
    // Flush while split with x3 and f4 busy; coincident writeback ignored.
    t0 = mk(RD_FP, 5'd4, 0, 5'd0, 0, 0); cyc();
    t0 = mk(RD_INT, 5'd3, 0, 5'd0, 0, 0); t1 = mk(RD_INT, 5'd9, 1, 5'd3, 0, 0); cyc();
    flush = 1; wb0_v = 1; wb0_fp = 1; wb0_rd = 5'd4; cyc();
    quiet(); cyc();
    // End of simulation with f9 outstanding; flush in DONE has no effect.
    t0 = mk(RD_FP, 5'd9, 0, 5'd0, 0, 0); cyc();
    t0 = mk(RD_NONE, 5'd0, 0, 5'd0, 0, 1); t1 = mk(RD_INT, 5'd2, 0, 5'd0, 0, 0); cyc();
    t0 = mk(RD_INT, 5'd1, 0, 5'd0, 0, 0); cyc(); cyc();
    quiet(); wb1_v = 1; wb1_fp = 1; wb1_rd = 5'd9; cyc();
    quiet(); cyc(); cyc();
    flush = 1; cyc();
    quiet(); t0 = mk(RD_INT, 5'd4, 0, 5'd0, 0, 0); cyc(); cyc();
    do_reset();
    // Random traffic, occasional flushes, end-of-sim and mid-operation resets.
    for (int n = 0; n < 3000; n++) begin
      if (($urandom % 250) == 0 || (m_mode == 3 && ($urandom % 8) == 0)) do_reset();
      t0 = rnd_slot(1'b1); t1 = rnd_slot(1'b1);
      flush  = ($urandom % 60) == 0;
      wb0_v  = ($urandom % 2) == 0; wb0_fp = 1'($urandom); wb0_rd = 5'($urandom % 8);
      wb1_v  = ($urandom % 3) == 0; wb1_fp = 1'($urandom); wb1_rd = 5'($urandom % 8);
      cyc();
    end
    quiet(); cyc();
    #5;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end, limit %0d", 2000000);
    $fatal(1);
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

In-order dual-issue hazard scoreboard that sequences the operand-read stage. It tracks which integer and FP architectural registers have an outstanding producer and checks the decoded instruction pair against that state. It drives the stall to the decoder and per-slot issue enables that gate the operand-stage valids. It also splits dependent pairs and drains the pipeline on end-of-simulation.

## Interface
- NREG, 32, architectural registers per file
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush from writeback
- instN_valid_i  in  1  slot N (N=0,1) decoded valid
- instN_rs1_valid_i / instN_rs2_valid_i / instN_rs3_valid_i  in  1 each  source used
- instN_rs1_i / instN_rs2_i / instN_rs3_i  in  5 each  source index
- instN_rs1_fp_i / instN_rs2_fp_i  in  1 each  source is FP; rs3 is always FP
- instN_rd_type_i  in  2  RD_NONE=0, RD_INT=1, RD_FP=2
- instN_rd_i  in  5  destination index
- instN_endsim_i  in  1  end-of-simulation marker
- wbN_valid_i  in  1  writeback port N valid
- wbN_rd_i  in  5  writeback destination
- wbN_fp_i  in  1  writeback targets FP file
- stall_o  out  1  hold decoder pair
- issue0_o / issue1_o  out  1 each  slot accepted into operand stage this cycle
- endsim_o  out  1  one-cycle pulse: machine drained after endsim
- int_busy_o / fp_busy_o  out  NREG each  busy vectors (debug)

## Operation
- Busy table: 2×32 bits. Issue of a slot with rd_type INT/FP sets busy[rd]; a writeback clears busy[wb_rd] in the selected file. Integer x0 is never set.
- Slot hazard: any valid source whose busy bit is set (RAW), or a destination whose busy bit is set (WAW). The check uses the registered busy state; same-cycle writeback clears are not bypassed.
- Intra-pair hazard: inst1 reads or writes inst0's destination (same file, excluding int x0).
- FSM states IDLE, HALF, DRAIN, DONE.
- IDLE, both slots hazard-free, no intra-pair hazard: issue0=issue1=1, stall=0.
- IDLE, inst0 blocked: issue0=issue1=0, stall=1.
- IDLE, inst0 free but inst1 blocked or intra-dependent: issue0=1, issue1=0, stall=1, next state HALF.
- HALF: inst0 is treated as consumed and only inst1 is evaluated. When it is free: issue1=1, stall=0, next state IDLE. Otherwise stall=1.
- Issuing slot with endsim=1: next state DRAIN. A younger slot in the same pair is not issued; the pair is treated as consumed.
- DRAIN: stall=1, no issue. When both busy vectors are zero: next state DONE and endsim_o=1 for one cycle.
- DONE: stall=1, no issue, until reset.
- flush_i (states IDLE/HALF/DRAIN): busy vectors cleared, next state IDLE, issue0=issue1=0, stall=0 that cycle. Writebacks coincident with flush are ignored. In DONE, flush is ignored.
- Same register set by issue and cleared by writeback in the same cycle: set wins.
- Both writeback ports naming the same register: cleared once, no error.

## Timing
- stall_o and issueN_o are combinational from registered state plus the current decoder/flush inputs.
- Busy updates and state changes take effect at the next clk rising edge. endsim_o is registered.
- Hazard clear latency: writeback in cycle n, dependent issue in cycle n+1 at the earliest.
- Reset (async assert, sync-to-clk deassert externally): busy=0, state IDLE, endsim_o=0. With valids low, all outputs are 0.
- Reset mid-DRAIN or mid-HALF returns to IDLE immediately.

## Structure
- Shared package: RD_NONE/RD_INT/RD_FP constants, sb_state_t enum (IDLE, HALF, DRAIN, DONE), NREG.
- Sub-module sb_busy_table: two 32-bit files with 2 set ports, 2 clear ports, synchronous clear-all, and set-over-clear priority. The top level holds the hazard compare logic and the FSM.

## Test plan
- Reset with random inputs: stall_o=0, issue0/1_o=0, endsim_o=0, busy vectors 0.
- Issue inst0 add x5 (INT) in cycle 0. Pair reading x5 from cycle 1: stall=1 until wb0 x5 in cycle 4; issue in cycle 5; int_busy[5]=0 after cycle 4.
- Pair inst0 writes x3, inst1 reads x3: cycle 0 issue0=1, issue1=0, stall=1, state HALF. wb x3 in cycle 2; issue1=1, stall=0 in cycle 3.
- Issue writing x7 while wb1 clears x7 in the same cycle: int_busy[7]=1 afterwards. An inst0 write to x0: int_busy[0] stays 0.
- In HALF with x3 and f4 busy, assert flush: next cycle busy=0, state IDLE. A coincident wb is ignored.
- endsim issued with f9 busy: stall=1, no issue. wb f9 in cycle k: endsim_o=1 in cycle k+1 only; stall stays 1 thereafter, and flush has no effect.
